// File: rtl/pipelined_barrel_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : barrel_pkg
// Brief   : Shift-mode type and mode encodings shared by the barrel shifter.
// Revision: 1.0 - initial release
// ============================================================================
package barrel_pkg;

    typedef logic [1:0] shift_mode_t;

    localparam shift_mode_t MODE_SLL = 2'b00;
    localparam shift_mode_t MODE_SRL = 2'b01;
    localparam shift_mode_t MODE_SRA = 2'b10;
    localparam shift_mode_t MODE_ROL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pipelined_barrel_shifter_if.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_barrel_shifter_if
// Brief   : Operand/result valid-ready streams of the pipelined barrel shifter.
// Revision: 1.0 - initial release
// ============================================================================
interface pipelined_barrel_shifter_if
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [SHW-1:0]    in_amt;
    shift_mode_t       in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    shift_mode_t       out_mode;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );

endinterface
`default_nettype wire

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
`default_nettype none
// ============================================================================
// Module  : shift_stage
// Brief   : One pipeline stage: conditional shift by DIST in the carried mode,
//           registered with hold while the pipeline is stalled.
// Revision: 1.0 - initial release
// ============================================================================
module shift_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               i_adv,
    input  wire               i_valid,
    input  wire [WIDTH-1:0]   i_data,
    input  wire [AMT_W-1:0]   i_amt,
    input  wire shift_mode_t  i_mode,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_data,
    output logic [AMT_W-1:0]  o_amt,
    output shift_mode_t       o_mode
);

    localparam int c_AMT_BIT = $clog2(DIST);

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_amt;
    shift_mode_t      r_mode;

    // SRA sign comes from the current MSB, which every earlier SRA stage preserved
    always_comb begin
        w_shifted = i_data;
        case (i_mode)
            MODE_SLL: w_shifted = i_data << DIST;
            MODE_SRL: w_shifted = i_data >> DIST;
            MODE_SRA: w_shifted = $signed(i_data) >>> DIST;
            default:  w_shifted = (i_data << DIST) | (i_data >> (WIDTH - DIST));
        endcase
        w_next = i_amt[c_AMT_BIT] ? w_shifted : i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= MODE_SLL;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_next;
                r_amt  <= i_amt;
                r_mode <= i_mode;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_mode  = r_mode;

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_barrel_shifter
// Brief   : WIDTH-bit SLL/SRL/SRA/ROL barrel shifter, one stage per amount bit,
//           valid/ready streaming at one result per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input wire                         clk,
    input wire                         rst,
    pipelined_barrel_shifter_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    logic             w_adv;
    logic             w_valid [0:SHW];
    logic [WIDTH-1:0] w_data  [0:SHW];
    logic [SHW-1:0]   w_amt   [0:SHW];
    shift_mode_t      w_mode  [0:SHW];
    logic             w_unused_amt;

    // Whole pipeline moves in lockstep; bubbles travel as valid=0
    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_valid[0] = bus.in_valid && w_adv;
    assign w_data[0]  = bus.in_data;
    assign w_amt[0]   = bus.in_amt;
    assign w_mode[0]  = bus.in_mode;

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .DIST  (1 << k),
                .AMT_W (SHW)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_adv   (w_adv),
                .i_valid (w_valid[k]),
                .i_data  (w_data[k]),
                .i_amt   (w_amt[k]),
                .i_mode  (w_mode[k]),
                .o_valid (w_valid[k+1]),
                .o_data  (w_data[k+1]),
                .o_amt   (w_amt[k+1]),
                .o_mode  (w_mode[k+1])
            );
        end
    endgenerate

    assign bus.out_valid = w_valid[SHW];
    assign bus.out_data  = w_data[SHW];
    assign bus.out_mode  = w_mode[SHW];
    assign w_unused_amt  = ^w_amt[SHW];

endmodule
`default_nettype wire
